// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz raster timing definition.
// Renderer, game logic and the timing generator all take their H/V sizes
// from here so there is exactly one definition of the visible area.
// Contents: default pixel divider, active/porch/sync widths, line and frame
// totals, sync window bounds, and a half-open window test helper.
package vga_timing_pkg;

  localparam int         VGA_CLK_DIV  = 2;

  localparam logic [9:0] VGA_H_ACTIVE = 10'd640;
  localparam logic [9:0] VGA_H_FP     = 10'd16;
  localparam logic [9:0] VGA_H_SYNC   = 10'd96;
  localparam logic [9:0] VGA_H_BP     = 10'd48;
  localparam logic [9:0] VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam logic [9:0] VGA_V_ACTIVE = 10'd480;
  localparam logic [9:0] VGA_V_FP     = 10'd10;
  localparam logic [9:0] VGA_V_SYNC   = 10'd2;
  localparam logic [9:0] VGA_V_BP     = 10'd33;
  localparam logic [9:0] VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows are half-open: [start, end).
  localparam logic [9:0] VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam logic [9:0] VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam logic [9:0] VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam logic [9:0] VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // True when lo <= v < hi (10-bit unsigned).
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_enable.sv
// Pixel-rate divider.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   pix_en  - one-clk strobe every CLK_DIV clks (when div is at its last count)
//   vga_clk - registered pixel clock for the DAC, high while div >= CLK_DIV/2
module vga_pixel_enable #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic vga_clk
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             vga_clk_reg;

  assign pix_en   = (div_reg == DIV_LAST);
  assign div_next = pix_en ? '0 : div_reg + 1'b1;

  // vga_clk is decoded from the next divider value so that in every clk
  // it reflects the divider count held in that same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg     <= '0;
      vga_clk_reg <= 1'b0;
    end else begin
      div_reg     <= div_next;
      vga_clk_reg <= (div_next >= DIV_HALF);
    end
  end

  assign vga_clk = vga_clk_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60Hz from a 50 MHz clk).
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   x, y          - registered column/line of the current pixel
//   active_pixels - registered visible-area flag
//   VGA_HS/VGA_VS - registered syncs, asserted level SYNC_POL
//   VGA_BLANK_N   - same as active_pixels
//   VGA_SYNC_N    - tied low (no sync-on-green)
//   VGA_CLK       - pixel clock to the DAC
//   frame_tick    - one-clk pulse when (x, y) first becomes (0, V_ACTIVE)
// All decoded outputs are registered from one counter snapshot, so they
// change together one clk after the counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int         CLK_DIV  = VGA_CLK_DIV,
  parameter logic [9:0] H_ACTIVE = VGA_H_ACTIVE,
  parameter logic [9:0] H_FP     = VGA_H_FP,
  parameter logic [9:0] H_SYNC   = VGA_H_SYNC,
  parameter logic [9:0] H_BP     = VGA_H_BP,
  parameter logic [9:0] V_ACTIVE = VGA_V_ACTIVE,
  parameter logic [9:0] V_FP     = VGA_V_FP,
  parameter logic [9:0] V_SYNC   = VGA_V_SYNC,
  parameter logic [9:0] V_BP     = VGA_V_BP,
  parameter logic       SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active_pixels,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_tick
);

  localparam logic [9:0] H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST  = V_TOTAL - 10'd1;

  // Index 0 = horizontal axis, index 1 = vertical axis.
  localparam logic [9:0] SYNC_START [2] = '{H_ACTIVE + H_FP, V_ACTIVE + V_FP};
  localparam logic [9:0] SYNC_END   [2] = '{H_ACTIVE + H_FP + H_SYNC,
                                            V_ACTIVE + V_FP + V_SYNC};

  logic       pix_en;
  logic       vga_clk_int;

  logic [9:0] h_cnt_reg;
  logic [9:0] v_cnt_reg;
  logic [9:0] axis_cnt [2];
  logic [1:0] sync_next;

  logic [9:0] x_reg;
  logic [9:0] y_reg;
  logic       active_reg;
  logic       hs_reg;
  logic       vs_reg;
  logic       frame_tick_reg;

  vga_pixel_enable #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_enable (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .vga_clk (vga_clk_int)
  );

  // Raster counters advance once per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 10'd1;
      end
    end
  end

  assign axis_cnt[0] = h_cnt_reg;
  assign axis_cnt[1] = v_cnt_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    assign sync_next[gi] = in_window(axis_cnt[gi], SYNC_START[gi], SYNC_END[gi])
                           ? SYNC_POL : ~SYNC_POL;
  end

  // Decode stage. frame_tick keys off the previous decoded x being the last
  // column, so it fires only on the first clk of pixel (0, V_ACTIVE) and not
  // on the remaining CLK_DIV-1 clks that repeat the same coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg          <= '0;
      y_reg          <= '0;
      active_reg     <= 1'b0;
      hs_reg         <= ~SYNC_POL;
      vs_reg         <= ~SYNC_POL;
      frame_tick_reg <= 1'b0;
    end else begin
      x_reg          <= h_cnt_reg;
      y_reg          <= v_cnt_reg;
      active_reg     <= (h_cnt_reg < H_ACTIVE) && (v_cnt_reg < V_ACTIVE);
      hs_reg         <= sync_next[0];
      vs_reg         <= sync_next[1];
      frame_tick_reg <= (h_cnt_reg == 10'd0) && (v_cnt_reg == V_ACTIVE) &&
                        (x_reg == H_LAST);
    end
  end

  assign x             = x_reg;
  assign y             = y_reg;
  assign active_pixels = active_reg;
  assign VGA_BLANK_N   = active_reg;
  assign VGA_HS        = hs_reg;
  assign VGA_VS        = vs_reg;
  assign VGA_SYNC_N    = 1'b0;
  assign VGA_CLK       = vga_clk_int;
  assign frame_tick    = frame_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Instance 0: default timing. Instance 1: CLK_DIV=4, active-high syncs.
  // Instance 2: a tiny raster so whole frames fit in a short run.
  localparam int N = 3;
  localparam int P_DIV [N] = '{2, 4, 2};
  localparam int P_HA  [N] = '{640, 640, 16};
  localparam int P_HF  [N] = '{16, 16, 4};
  localparam int P_HS  [N] = '{96, 96, 8};
  localparam int P_HB  [N] = '{48, 48, 4};
  localparam int P_VA  [N] = '{480, 480, 12};
  localparam int P_VF  [N] = '{10, 10, 2};
  localparam int P_VS  [N] = '{2, 2, 2};
  localparam int P_VB  [N] = '{33, 33, 3};
  localparam int P_POL [N] = '{0, 1, 0};

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       vclk;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst     [N];
  logic [9:0] x       [N];
  logic [9:0] y       [N];
  logic       act     [N];
  logic       hs      [N];
  logic       vs      [N];
  logic       blank_n [N];
  logic       sync_n  [N];
  logic       vclk    [N];
  logic       tick    [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Arithmetic reference: k = number of clk edges since reset was last
  // sampled (0 = still in reset). Decoded outputs after edge k show pixel
  // number (k-1)/CLK_DIV of the raster.
  function automatic exp_t model(input int i, input int k);
    exp_t e;
    int   d, ht, vt, p, xx, yy, hss, vss;
    logic pol;
    d   = P_DIV[i];
    ht  = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
    vt  = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
    pol = (P_POL[i] != 0);
    if (k == 0) begin
      e.x = 10'd0; e.y = 10'd0; e.act = 1'b0; e.hs = ~pol; e.vs = ~pol;
      e.vclk = 1'b0; e.tick = 1'b0;
    end else begin
      p   = (k - 1) / d;
      xx  = p % ht;
      yy  = (p / ht) % vt;
      hss = P_HA[i] + P_HF[i];
      vss = P_VA[i] + P_VF[i];
      e.x    = 10'(xx);
      e.y    = 10'(yy);
      e.act  = (xx < P_HA[i]) && (yy < P_VA[i]);
      e.hs   = (xx >= hss && xx < hss + P_HS[i]) ? pol : ~pol;
      e.vs   = (yy >= vss && yy < vss + P_VS[i]) ? pol : ~pol;
      e.vclk = ((k % d) >= d / 2);
      e.tick = (xx == 0) && (yy == P_VA[i]) && (((k - 1) % d) == 0);
    end
    return e;
  endfunction

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV  (P_DIV[gi]),
      .H_ACTIVE (10'(P_HA[gi])),
      .H_FP     (10'(P_HF[gi])),
      .H_SYNC   (10'(P_HS[gi])),
      .H_BP     (10'(P_HB[gi])),
      .V_ACTIVE (10'(P_VA[gi])),
      .V_FP     (10'(P_VF[gi])),
      .V_SYNC   (10'(P_VS[gi])),
      .V_BP     (10'(P_VB[gi])),
      .SYNC_POL (1'(P_POL[gi]))
    ) u_dut (
      .clk           (clk),
      .rst           (rst[gi]),
      .x             (x[gi]),
      .y             (y[gi]),
      .active_pixels (act[gi]),
      .VGA_HS        (hs[gi]),
      .VGA_VS        (vs[gi]),
      .VGA_BLANK_N   (blank_n[gi]),
      .VGA_SYNC_N    (sync_n[gi]),
      .VGA_CLK       (vclk[gi]),
      .frame_tick    (tick[gi])
    );

    exp_t sb_q [$];

    // Scoreboard: once rst for the coming edge is driven (negedge), push the
    // expected post-edge state; pop and compare just after the edge.
    initial begin : mon
      int   k;
      exp_t e;
      k = 0;
      forever begin
        @(negedge clk); #1;
        if (rst[gi]) k = 0; else k = k + 1;
        sb_q.push_back(model(gi, k));
        @(posedge clk); #1;
        e = sb_q.pop_front();
        checks++;
        if ({x[gi], y[gi], act[gi], hs[gi], vs[gi], blank_n[gi], sync_n[gi], vclk[gi], tick[gi]} !==
            {e.x, e.y, e.act, e.hs, e.vs, e.act, 1'b0, e.vclk, e.tick}) begin
          errors++;
          $display("FAIL scoreboard dut%0d k=%0d got x=%0d y=%0d act=%b hs=%b vs=%b bn=%b sn=%b vclk=%b tick=%b want x=%0d y=%0d act=%b hs=%b vs=%b bn=%b sn=0 vclk=%b tick=%b",
                   gi, k, x[gi], y[gi], act[gi], hs[gi], vs[gi], blank_n[gi], sync_n[gi], vclk[gi], tick[gi],
                   e.x, e.y, e.act, e.hs, e.vs, e.act, e.vclk, e.tick);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    rst[0] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (x[0] !== 10'd0 || y[0] !== 10'd0 || act[0] !== 1'b0 || blank_n[0] !== 1'b0 ||
        hs[0] !== 1'b1 || vs[0] !== 1'b1 || vclk[0] !== 1'b0 || tick[0] !== 1'b0 || sync_n[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got x=%0d y=%0d act=%b bn=%b hs=%b vs=%b vclk=%b tick=%b sn=%b want 0 0 0 0 1 1 0 0 0",
               x[0], y[0], act[0], blank_n[0], hs[0], vs[0], vclk[0], tick[0], sync_n[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (x[0] !== 10'd1 && n < 10);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL x_first_step got %0d clks want 3", n);
    end
    n = 0;
    while (x[0] === 10'd1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2 || x[0] !== 10'd2) begin
      errors++;
      $display("FAIL x_step_period got %0d clks to x=%0d want 2 clks to x=2", n, x[0]);
    end
    $display("test_reset: done");
  endtask

  task automatic test_line_timing(input int i);
    int   d, ht, c, prev, n_act, n_sync, sync_x, per;
    logic pol;
    bit   found;
    d   = P_DIV[i];
    ht  = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
    pol = (P_POL[i] != 0);
    found = 0;
    c = 0;
    prev = int'(x[i]);
    while (!found && c < d * ht + 10) begin
      @(posedge clk); #1;
      c++;
      if (x[i] === 10'd0 && prev == ht - 1) found = 1;
      prev = int'(x[i]);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL line_start dut%0d no line start within %0d clks", i, c);
    end
    n_act = 0; n_sync = 0; sync_x = -1; per = 0; c = 0;
    while (per == 0 && c < 2 * d * ht) begin
      if (act[i] === 1'b1) n_act++;
      if (hs[i] === pol) begin
        if (n_sync == 0) sync_x = int'(x[i]);
        n_sync++;
      end
      prev = int'(x[i]);
      @(posedge clk); #1;
      c++;
      if (x[i] === 10'd0 && prev == ht - 1) per = c;
    end
    checks++;
    if (n_act != d * P_HA[i]) begin
      errors++;
      $display("FAIL line_active dut%0d got %0d clks want %0d", i, n_act, d * P_HA[i]);
    end
    checks++;
    if (n_sync != d * P_HS[i] || sync_x != P_HA[i] + P_HF[i]) begin
      errors++;
      $display("FAIL line_hsync dut%0d got %0d clks from x=%0d want %0d clks from x=%0d",
               i, n_sync, sync_x, d * P_HS[i], P_HA[i] + P_HF[i]);
    end
    checks++;
    if (per != d * ht) begin
      errors++;
      $display("FAIL line_period dut%0d got %0d want %0d", i, per, d * ht);
    end
    $display("test_line_timing dut%0d: active=%0d hsync=%0d@x=%0d period=%0d", i, n_act, n_sync, sync_x, per);
  endtask

  task automatic test_mid_frame_reset();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (x[0] !== 10'd300 && n < 2000);
    checks++;
    if (x[0] !== 10'd300) begin
      errors++;
      $display("FAIL mid_reset_wait got x=%0d want 300", x[0]);
    end
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (x[0] !== 10'd0 || y[0] !== 10'd0 || hs[0] !== 1'b1 || vs[0] !== 1'b1 ||
        tick[0] !== 1'b0 || act[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state got x=%0d y=%0d hs=%b vs=%b tick=%b act=%b want 0 0 1 1 0 0",
               x[0], y[0], hs[0], vs[0], tick[0], act[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (x[0] !== 10'd1 && n < 10);
    checks++;
    if (n != 3 || y[0] !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_resume got x=1 after %0d clks y=%0d want 3 clks y=0", n, y[0]);
    end
    $display("test_mid_frame_reset: done");
  endtask

  task automatic test_frame_timing();
    int c, n_tick, first_t, last_t, n_vs, vs_y, bad;
    rst[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (tick[2] !== 1'b1 && c < 3000);
    checks++;
    if (c != 769 || y[2] !== 10'd12 || x[2] !== 10'd0) begin
      errors++;
      $display("FAIL first_tick got clk %0d at x=%0d y=%0d want clk 769 at x=0 y=12", c, x[2], y[2]);
    end
    n_tick = 0; first_t = -1; last_t = -1; n_vs = 0; vs_y = -1; bad = 0;
    for (int t = 1; t <= 2433; t++) begin
      @(posedge clk); #1;
      if (tick[2] === 1'b1) begin
        n_tick++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
      if (t <= 1216 && vs[2] === 1'b0) begin
        if (n_vs == 0) vs_y = int'(y[2]);
        n_vs++;
      end
      if (act[2] === 1'b1 && y[2] >= 10'd12) bad++;
    end
    checks++;
    if (n_tick != 2 || first_t != 1216 || last_t != 2432) begin
      errors++;
      $display("FAIL frame_period got %0d ticks at %0d and %0d want 2 ticks at 1216 and 2432", n_tick, first_t, last_t);
    end
    checks++;
    if (n_vs != 128 || vs_y != 14) begin
      errors++;
      $display("FAIL frame_vsync got %0d clks from y=%0d want 128 clks from y=14", n_vs, vs_y);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_blank_active got %0d active clks below visible area want 0", bad);
    end
    $display("test_frame_timing: ticks=%0d period=%0d vsync=%0d@y=%0d", n_tick, first_t, n_vs, vs_y);
  endtask

  task automatic test_wrap_boundary();
    int n;
    n = 0;
    while (!(x[2] === 10'd31 && y[2] === 10'd18) && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (x[2] === 10'd31 && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (x[2] !== 10'd0 || y[2] !== 10'd0 || act[2] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_frame got x=%0d y=%0d act=%b want 0 0 1", x[2], y[2], act[2]);
    end
    n = 0;
    while (!(x[2] === 10'd31 && y[2] === 10'd11) && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (x[2] === 10'd31 && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (x[2] !== 10'd0 || y[2] !== 10'd12 || act[2] !== 1'b0 || tick[2] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_vblank got x=%0d y=%0d act=%b tick=%b want 0 12 0 1", x[2], y[2], act[2], tick[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (tick[2] !== 1'b0 || x[2] !== 10'd0) begin
      errors++;
      $display("FAIL tick_width got tick=%b x=%0d want tick=0 x=0", tick[2], x[2]);
    end
    $display("test_wrap_boundary: done");
  endtask

  task automatic test_param_variant();
    int   n;
    logic prev;
    logic [3:0] pat;
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    test_line_timing(1);
    n = 0;
    prev = vclk[1];
    do begin
      prev = vclk[1];
      @(posedge clk); #1;
      n++;
    end while (!(prev === 1'b0 && vclk[1] === 1'b1) && n < 20);
    for (int t = 3; t >= 0; t--) begin
      @(posedge clk); #1;
      pat[t] = vclk[1];
    end
    checks++;
    if (pat !== 4'b1001) begin
      errors++;
      $display("FAIL vga_clk_duty got pattern %b after rise want 1001", pat);
    end
    $display("test_param_variant: vga_clk pattern %b", pat);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation did not finish CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < N; i++) rst[i] = 1'b1;
    test_reset();
    test_line_timing(0);
    test_mid_frame_reset();
    test_frame_timing();
    test_wrap_boundary();
    test_param_variant();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
